regbank_bist: RTL and testbench
===============================

# regbank_bist

Built-in self-test controller for the MIPS register bank (`regbank`). It drives the bank's write port (`a3`/`wd3`/`we3`) and both read ports (`a1`/`a2`) through a fixed four-pattern march and compares `rd1`/`rd2` against expected data. It reports pass/fail, a saturating error count and the first failing register. It sits beside the datapath and owns the bank's ports only while `busy` is high; the top-level mux selecting between the datapath and the BIST is outside this block.

## Interface
- No parameters; data width 32 and address width 5 are fixed by `regbank`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  one-cycle request to run the test; honoured only in IDLE.
- `rd1`  in  32  bank read data for `a1`; combinational in `a1`.
- `rd2`  in  32  bank read data for `a2`; combinational in `a2`.
- `a1`  out  5  read address, port 1 (registered).
- `a2`  out  5  read address, port 2 (registered).
- `a3`  out  5  write address (registered).
- `wd3`  out  32  write data (registered).
- `we3`  out  1  write enable (registered); the bank writes on the `clk` rising edge when `we3`=1.
- `busy`  out  1  high while in the WRITE or READ states.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  1 when the last completed run had `err_count`=0; held until the next `start`.
- `err_count`  out  8  mismatches in the current or last run; saturates at 255.
- `fail_addr`  out  5  register address of the first mismatch in the run.
- `fail_valid`  out  1  set on the first mismatch in the run.

## Operation
- States: IDLE, WRITE, READ, DONE. A 2-bit pass counter `p` (0..3) and a 5-bit index `i` (0..31).
- Patterns, as a function of register address `r`:
  - PAT0 = 32'h5555_5555
  - PAT1 = 32'hAAAA_AAAA
  - PAT2 = {2'b10, {6{r}}}
  - PAT3 = ~PAT2
- Expected read value: exp(r) = 0 for r=0 (`$0` is hardwired), otherwise PATp(r).
- IDLE: `we3`=0, `busy`=0. If `start`=1, then on the next edge: `p`=0, `i`=0, clear `err_count`, `fail_valid`, `fail_addr` and `pass`, and go to WRITE.
- WRITE, each cycle `i`: `a3`=i, `wd3`=PATp(i), `we3`=1. Register 0 is written deliberately to check that the write is ignored.
  - At `i`=31, go to READ with `i`=0.
- READ, each cycle `i`: `a1`=i, `a2`=31−i, `we3`=0.
  - At the closing edge, compare `rd1` with exp(i) and `rd2` with exp(31−i). Each mismatching port adds 1 to `err_count`, so a cycle can add 0, 1 or 2, saturating at 255.
  - On the first mismatch of the run, set `fail_valid`=1. `fail_addr` takes the rd1 address if rd1 mismatches, otherwise the rd2 address.
  - At `i`=31: if `p`<3, increment `p` and go to WRITE; if `p`=3, go to DONE.
- DONE (one cycle): `done`=1, `busy`=0, and `pass` is set to (`err_count`==0), including any count added in the final READ cycle. Next state is IDLE.
- `start` is ignored in WRITE, READ and DONE.
- Output drive: address and data outputs come straight from registers. In IDLE and DONE, `a1`, `a2`, `a3` and `wd3` hold their last values and `we3`=0.

## Timing
- Reset (`rst`=0 at an edge), in any state: next state is IDLE, and all outputs become 0 (`a1`, `a2`, `a3`, `wd3`, `we3`, `busy`, `done`, `pass`, `err_count`, `fail_addr`, `fail_valid`).
  - A run in progress is aborted and `done` is not pulsed.
  - `we3` is low from the reset edge onward, so no partial write follows reset.
- Edge numbering: `start` is sampled high at edge E.
  - The WRITE state with `i`=0 is active in the cycle E..E+1.
  - Each pass is 64 cycles (32 WRITE + 32 READ); 4 passes total 256 cycles.
  - `busy`=1 from E through E+256; DONE occupies E+256..E+257 with `done`=1.
  - IDLE is re-entered at E+257, and a new `start` is accepted from that cycle.
- Read latency: zero wait states. Data for address `a1` is valid in the same cycle and is sampled at that cycle's closing edge.
- Write-to-read spacing is at least one full cycle, so read-during-write ordering in the bank is irrelevant.

## Test plan
- Fault-free `regbank`, `start` pulse: `busy` high for 256 cycles, `done` at E+256, `pass`=1, `err_count`=0, `fail_valid`=0.
- Bank model with register 7 bit 3 stuck-at-0:
  - Only PAT1 and PAT3 have bit 3 set; reg 7 is read twice per pass.
  - Expect `err_count`=4, `fail_addr`=7, `fail_valid`=1, `pass`=0.
- Bank model in which writes to register 0 are stored: expect `err_count`=8 (rd1 at `i`=0 and rd2 at `i`=31, in all four passes), `fail_addr`=0, `pass`=0.
- Bank model returning ~exp on both ports: expect `err_count`=255 (saturated, out of 256 true mismatches), `fail_addr`=0, `pass`=0.
- Reset and restart:
  - `start`, then `rst`=0 at E+100: next cycle all outputs are 0, `we3`=0, no `done`.
  - A new `start` after reset runs a complete test and yields `pass`=1.
- `start` re-pulsed at E+5 and at E+256 (DONE): both are ignored; `done` occurs exactly once at E+256 and `err_count` is unchanged.

Source files
------------

// File: rtl/regbank_bist.sv
// March-pattern self-test for the 32x32 MIPS register bank. Writes four patterns
// through the bank's write port and checks both read ports against them.
module regbank_bist (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] rd1,
   input  logic [31:0] rd2,
   output logic [4:0]  a1,
   output logic [4:0]  a2,
   output logic [4:0]  a3,
   output logic [31:0] wd3,
   output logic        we3,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  err_count,
   output logic [4:0]  fail_addr,
   output logic        fail_valid
);

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t              state, state_nxt;
   logic [1:0]          p, p_nxt;
   logic [ADDR_W-1:0]   i, i_nxt;
   logic [DATA_W-1:0]   exp1, exp2;
   logic                mis1, mis2;
   logic [7:0]          err_nxt;

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] pp, input logic [ADDR_W-1:0] r);
      logic [DATA_W-1:0] v;
      case (pp)
         2'd0:    v = 32'h5555_5555;
         2'd1:    v = 32'hAAAA_AAAA;
         2'd2:    v = {2'b10, {6{r}}};
         default: v = ~{2'b10, {6{r}}};
      endcase
      return v;
   endfunction

   // $0 is hardwired to zero, so its expected read value ignores the pattern.
   function automatic logic [DATA_W-1:0] expected(input logic [1:0] pp, input logic [ADDR_W-1:0] r);
      return (r == '0) ? '0 : pattern(pp, r);
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] n);
      logic [8:0] s;
      s = {1'b0, c} + {7'd0, n};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   always_comb begin
      state_nxt = state;
      p_nxt     = p;
      i_nxt     = i;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = WRITE;
               p_nxt     = 2'd0;
               i_nxt     = '0;
            end
         end
         WRITE: begin
            i_nxt = i + 5'd1;
            if (i == 5'd31) state_nxt = READ;
         end
         READ: begin
            i_nxt = i + 5'd1;
            if (i == 5'd31) begin
               if (p == 2'd3) begin
                  state_nxt = DONE;
               end else begin
                  p_nxt     = p + 2'd1;
                  state_nxt = WRITE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Port 2 walks downward; 31-i is the bitwise complement for a 5-bit index.
   always_comb begin
      exp1    = expected(p, i);
      exp2    = expected(p, ~i);
      mis1    = (state == READ) && (rd1 != exp1);
      mis2    = (state == READ) && (rd2 != exp2);
      err_nxt = sat_add(err_count, {1'b0, mis1} + {1'b0, mis2});
   end

   assign busy = (state == WRITE) || (state == READ);
   assign done = (state == DONE);

   // Bank-facing outputs are loaded with the values for the upcoming cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         p          <= 2'd0;
         i          <= '0;
         a1         <= '0;
         a2         <= '0;
         a3         <= '0;
         wd3        <= '0;
         we3        <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 8'd0;
         fail_addr  <= '0;
         fail_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         p     <= p_nxt;
         i     <= i_nxt;
         we3   <= (state_nxt == WRITE);
         if (state_nxt == WRITE) begin
            a3  <= i_nxt;
            wd3 <= pattern(p_nxt, i_nxt);
         end
         if (state_nxt == READ) begin
            a1 <= i_nxt;
            a2 <= ~i_nxt;
         end
         if (state == IDLE && start) begin
            err_count  <= 8'd0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            pass       <= 1'b0;
         end else if (state == READ) begin
            err_count <= err_nxt;
            if (!fail_valid && (mis1 || mis2)) begin
               fail_valid <= 1'b1;
               fail_addr  <= mis1 ? i : ~i;
            end
         end
         if (state_nxt == DONE) pass <= (err_nxt == 8'd0);
      end
   end

endmodule

// File: tb/tb_regbank_bist.sv
// Bench for regbank_bist: behavioural bank with injectable faults and a
// scoreboard of per-run expected results checked when the run reports.
module tb_regbank_bist;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] rd1, rd2;
   logic [4:0]  a1, a2, a3;
   logic [31:0] wd3;
   logic        we3, busy, done, pass;
   logic [7:0]  err_count;
   logic [4:0]  fail_addr;
   logic        fail_valid;

   typedef struct packed {
      logic [7:0] err;
      logic [4:0] fa;
      logic       fv;
      logic       ps;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          fails = 0;
   int          bank_mode = 0;
   logic [31:0] mem [32];

   regbank_bist dut (
      .clk(clk), .rst(rst), .start(start), .rd1(rd1), .rd2(rd2),
      .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .we3(we3),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_addr(fail_addr), .fail_valid(fail_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (we3) mem[a3] <= wd3;

   // Mode 0 healthy, 1 reg7 bit3 stuck-at-0, 2 reg0 writable, 3 inverted reads.
   function automatic logic [31:0] bank_rd(input int mode, input logic [4:0] a, input logic [31:0] v);
      logic [31:0] r;
      r = (a == 5'd0) ? 32'd0 : v;
      case (mode)
         1: if (a == 5'd7) r[3] = 1'b0;
         2: r = v;
         3: r = ~r;
         default: ;
      endcase
      return r;
   endfunction

   always_comb begin
      rd1 = bank_rd(bank_mode, a1, mem[a1]);
      rd2 = bank_rd(bank_mode, a2, mem[a2]);
   end

   function automatic logic [31:0] pat(input int pp, input logic [4:0] r);
      logic [31:0] p2;
      p2 = {2'b10, r, r, r, r, r, r};
      if (pp == 0) return 32'h5555_5555;
      if (pp == 1) return 32'hAAAA_AAAA;
      if (pp == 2) return p2;
      return ~p2;
   endfunction

   function automatic exp_t mk(input logic [7:0] e, input logic [4:0] fa, input logic fv, input logic ps);
      exp_t x;
      x.err = e; x.fa = fa; x.fv = fv; x.ps = ps;
      return x;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic run(input int mode, input exp_t e, input bit repulse, input int abort_at);
      int   busy_cnt;
      int   done_cnt;
      int   done_n;
      exp_t got;
      busy_cnt  = 0;
      done_cnt  = 0;
      done_n    = -1;
      bank_mode = mode;
      @(negedge clk);
      start = 1'b1;
      sb.push_back(e);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_n = n;
         end
         if (n == 0) begin
            check("first_we3", {31'd0, we3}, 32'd1);
            check("first_a3", {27'd0, a3}, 32'd0);
            check("first_wd3", wd3, pat(0, 5'd0));
         end
         if (n == 32) begin
            check("read0_a1", {27'd0, a1}, 32'd0);
            check("read0_a2", {27'd0, a2}, 32'd31);
            check("read0_we3", {31'd0, we3}, 32'd0);
         end
         if (abort_at == 0 && n == 70) begin
            check("p1_a3", {27'd0, a3}, 32'd6);
            check("p1_wd3", wd3, pat(1, 5'd6));
         end
         if (abort_at == 0 && n == 100) begin
            check("p1_a1", {27'd0, a1}, 32'd4);
            check("p1_a2", {27'd0, a2}, 32'd27);
         end
         if (abort_at == 0 && n == 130) check("p2_wd3", wd3, pat(2, 5'd2));
         if (abort_at > 0 && n == abort_at) begin
            got = sb.pop_front();
            check("rst_addrs", {17'd0, a1, a2, a3}, 32'd0);
            check("rst_wd3", wd3, 32'd0);
            check("rst_ctrl", {27'd0, we3, busy, done, pass, fail_valid}, 32'd0);
            check("rst_err", {24'd0, err_count}, {24'd0, got.err});
            check("rst_faddr", {27'd0, fail_addr}, {27'd0, got.fa});
            rst = 1'b1;
         end
         if (done) begin
            if (sb.size() > 0) begin
               got = sb.pop_front();
               check("done_err", {24'd0, err_count}, {24'd0, got.err});
               check("done_faddr", {27'd0, fail_addr}, {27'd0, got.fa});
               check("done_fvalid", {31'd0, fail_valid}, {31'd0, got.fv});
               check("done_pass", {31'd0, pass}, {31'd0, got.ps});
            end else begin
               check("done_unexpected", {31'd0, done}, 32'd0);
            end
            check("done_busy_we3", {30'd0, busy, we3}, 32'd0);
         end
         start = repulse && (n == 4 || n == 255 || n == 256);
         if (abort_at > 0 && n == abort_at - 1) rst = 1'b0;
      end
      if (abort_at > 0) begin
         check("abort_done_cnt", done_cnt, 32'd0);
         check("abort_busy_cnt", busy_cnt, abort_at);
      end else begin
         check("done_cnt", done_cnt, 32'd1);
         check("done_cycle", done_n, 32'd256);
         check("busy_cycles", busy_cnt, 32'd256);
      end
      check("held_err", {24'd0, err_count}, {24'd0, e.err});
      check("held_pass", {31'd0, pass}, {31'd0, e.ps});
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_addrs", {17'd0, a1, a2, a3}, 32'd0);
      check("reset_wd3", wd3, 32'd0);
      check("reset_ctrl", {27'd0, we3, busy, done, pass, fail_valid}, 32'd0);
      check("reset_err", {24'd0, err_count}, 32'd0);
      check("reset_faddr", {27'd0, fail_addr}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      run(0, mk(8'd0,   5'd0, 1'b0, 1'b1), 1'b0, 0);
      run(1, mk(8'd4,   5'd7, 1'b1, 1'b0), 1'b0, 0);
      run(2, mk(8'd8,   5'd0, 1'b1, 1'b0), 1'b0, 0);
      run(3, mk(8'd255, 5'd0, 1'b1, 1'b0), 1'b0, 0);
      run(0, mk(8'd0,   5'd0, 1'b0, 1'b0), 1'b0, 100);
      run(0, mk(8'd0,   5'd0, 1'b0, 1'b1), 1'b0, 0);
      run(1, mk(8'd4,   5'd7, 1'b1, 1'b0), 1'b1, 0);

      check("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
